// File: rtl/core_lsu_issue_pkg.sv
// core_lsu_issue_pkg: shared widths, LSU op bit indices, trap causes and LSU issue types
package core_lsu_issue_pkg;
  localparam int XLEN = 64;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;
  localparam int LSU_OP_LOAD = 0;
  localparam int LSU_OP_STORE = 1;
  localparam int LSU_OP_BYTE = 2;
  localparam int LSU_OP_HALF = 3;
  localparam int LSU_OP_WORD = 4;
  localparam int LSU_OP_DOUBLE = 5;
  localparam int LSU_OP_SEXT = 6;
  localparam int LSU_OP_W = 7;
  localparam int CF_CAUSE_W = 6;
  localparam logic [CF_CAUSE_W-1:0] TRAP_LDALIGN = 6'd4;
  localparam logic [CF_CAUSE_W-1:0] TRAP_STALIGN = 6'd6;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} lsu_state_t;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: byte-lane strobe, store data alignment and misalignment detection
module core_lsu_align
  import core_lsu_issue_pkg::*;
(
  input  logic [2:0]            off,
  input  logic                  half,
  input  logic                  word,
  input  logic                  dbl,
  input  logic [XLEN-1:0]       rs2,
  output logic [MEM_STRB_W-1:0] strb,
  output logic [MEM_DATA_W-1:0] wdata,
  output logic                  misaligned
);
  always_comb begin
    strb = dbl ? 8'hFF : word ? 8'h0F << off : half ? 8'h03 << off : 8'h01 << off;
    wdata = rs2 << {off, 3'b000};
    misaligned = (half && off[0]) || (word && off[1:0] != 2'b00) || (dbl && off != 3'b000);
  end
endmodule

// File: rtl/core_lsu_issue.sv
// core_lsu_issue: s2->s3 slice issuing dmem requests, holding them stable until granted
module core_lsu_issue
  import core_lsu_issue_pkg::*;
(
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  s2_valid,
  output logic                  s2_ready,
  input  logic [XLEN-1:0]       s2_pc,
  input  logic [LSU_OP_W-1:0]   s2_lsu_op,
  input  logic [XLEN-1:0]       s2_addr,
  input  logic [XLEN-1:0]       s2_rs2,
  input  logic                  s2_trap,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic                  dmem_wen,
  output logic [MEM_STRB_W-1:0] dmem_strb,
  output logic [MEM_DATA_W-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  output logic                  s3_valid,
  input  logic                  s3_ready,
  output logic [XLEN-1:0]       s3_pc,
  output logic [XLEN-1:0]       s3_wdata,
  output logic [LSU_OP_W-1:0]   s3_lsu_op,
  output logic                  s3_trap,
  output logic [CF_CAUSE_W-1:0] s3_trap_cause
);
  lsu_state_t state, state_nxt;
  dmem_req_t live, hold;
  logic mis, is_lsu, trap_any, needs_mem, slot_free, s3_load;
  logic [MEM_STRB_W-1:0] strb;
  logic [MEM_DATA_W-1:0] wdata;
  core_lsu_align u_align (
    .off       (s2_addr[2:0]),
    .half      (s2_lsu_op[LSU_OP_HALF]),
    .word      (s2_lsu_op[LSU_OP_WORD]),
    .dbl       (s2_lsu_op[LSU_OP_DOUBLE]),
    .rs2       (s2_rs2),
    .strb      (strb),
    .wdata     (wdata),
    .misaligned(mis)
  );
  assign is_lsu = s2_lsu_op[LSU_OP_LOAD] || s2_lsu_op[LSU_OP_STORE];
  assign trap_any = s2_trap || (is_lsu && mis);
  assign needs_mem = is_lsu && !trap_any;
  assign slot_free = !s3_valid || s3_ready;
  assign live = '{addr: {s2_addr[MEM_ADDR_W-1:3], 3'b000}, wen: s2_lsu_op[LSU_OP_STORE], strb: strb, wdata: wdata};
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state <= ST_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == ST_IDLE ? (dmem_req && !dmem_gnt ? ST_WAIT : ST_IDLE) :
                dmem_gnt ? ST_IDLE : state == ST_WAIT && flush ? ST_DRAIN : state;
  end
  // Reset also gates the request so it drops without waiting for a clock edge
  always_comb begin
    dmem_req = g_resetn && (state != ST_IDLE || (s2_valid && needs_mem && slot_free && !flush));
    s2_ready = state == ST_IDLE ? (needs_mem ? dmem_req && dmem_gnt : slot_free) : state == ST_WAIT && dmem_gnt;
    s3_load = s2_valid && s2_ready && !flush;
    {dmem_addr, dmem_wen, dmem_strb, dmem_wdata} = state == ST_IDLE ? live : hold;
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      s3_valid <= 1'b0;
      s3_pc <= '0;
      s3_wdata <= '0;
      s3_lsu_op <= '0;
      s3_trap <= 1'b0;
      s3_trap_cause <= '0;
      hold <= '0;
    end else begin
      if (s3_load) begin
        s3_valid <= 1'b1;
        s3_pc <= s2_pc;
        s3_wdata <= s2_addr;
        s3_lsu_op <= s2_lsu_op;
        s3_trap <= trap_any;
        s3_trap_cause <= (is_lsu && mis && !s2_trap) ? (s2_lsu_op[LSU_OP_LOAD] ? TRAP_LDALIGN : TRAP_STALIGN) : '0;
      end else if (flush || s3_ready) s3_valid <= 1'b0;
      if (state == ST_IDLE && dmem_req && !dmem_gnt) hold <= live;
    end
  end
endmodule

// File: tb/tb_core_lsu_issue.sv
// tb_core_lsu_issue: directed literal checks plus random traffic against a transaction-level model
module tb_core_lsu_issue;
  import core_lsu_issue_pkg::*;
  localparam logic [6:0] OP_LD = 7'h01, OP_ST = 7'h02, OP_B = 7'h04, OP_H = 7'h08, OP_W = 7'h10, OP_D = 7'h20, OP_SX = 7'h40;
  logic g_clk = 0, g_resetn = 0;
  logic s2_valid = 0, s2_ready, s2_trap = 0, flush = 0;
  logic [6:0] s2_lsu_op = 0;
  logic [63:0] s2_pc = 0, s2_addr = 0, s2_rs2 = 0;
  logic dmem_req, dmem_wen, dmem_gnt = 0, s3_valid, s3_ready = 1, s3_trap;
  logic [63:0] dmem_addr, dmem_wdata, s3_pc, s3_wdata;
  logic [7:0] dmem_strb;
  logic [6:0] s3_lsu_op;
  logic [5:0] s3_trap_cause;
  int vectors = 0, miscompares = 0;
  bit acc;
  bit m_pend, m_kill, m_s3v, m_trap, p_wen;
  logic [63:0] p_addr, p_wdata, m_pc, m_wdata;
  logic [7:0] p_strb;
  logic [6:0] m_op;
  logic [5:0] m_cause;

  core_lsu_issue dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_pc(s2_pc),
    .s2_lsu_op(s2_lsu_op), .s2_addr(s2_addr), .s2_rs2(s2_rs2), .s2_trap(s2_trap), .flush(flush),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .s3_valid(s3_valid), .s3_ready(s3_ready),
    .s3_pc(s3_pc), .s3_wdata(s3_wdata), .s3_lsu_op(s3_lsu_op), .s3_trap(s3_trap), .s3_trap_cause(s3_trap_cause)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [63:0] a, input logic [63:0] d,
                       input logic t, input logic f, input logic g);
    @(posedge g_clk);
    #1;
    s2_valid = v; s2_lsu_op = op; s2_addr = a; s2_rs2 = d; s2_pc = a + 64'h100000;
    s2_trap = t; flush = f; dmem_gnt = g;
    @(negedge g_clk);
  endtask

  // Model: at most one outstanding transaction (possibly killed by flush) plus the s3 slot
  always @(negedge g_clk) begin : model
    int sz, m;
    logic [2:0] off;
    logic lsu, mis, trp, e_req, e_ready, e_load, e_wen, free;
    logic [5:0] cause;
    logic [63:0] e_addr, e_wdata;
    logic [7:0] e_strb;
    if (!g_resetn) begin
      m_pend = 0; m_kill = 0; m_s3v = 0; acc = 0;
    end else begin
      off = s2_addr[2:0];
      sz = s2_lsu_op[5] ? 8 : s2_lsu_op[4] ? 4 : s2_lsu_op[3] ? 2 : 1;
      lsu = s2_lsu_op[0] | s2_lsu_op[1];
      mis = lsu && (int'(off) % sz != 0);
      trp = s2_trap || mis;
      cause = (mis && !s2_trap) ? (s2_lsu_op[0] ? 6'd4 : 6'd6) : 6'd0;
      m = ((1 << sz) - 1) << off;
      free = !m_s3v || s3_ready;
      if (m_pend) begin
        e_addr = p_addr; e_wen = p_wen; e_strb = p_strb; e_wdata = p_wdata;
        e_req = 1; e_ready = !m_kill && dmem_gnt;
      end else begin
        e_addr = s2_addr & ~64'h7; e_wen = s2_lsu_op[1]; e_strb = m[7:0]; e_wdata = s2_rs2 << (8 * off);
        e_req = s2_valid && lsu && !trp && free && !flush;
        e_ready = (lsu && !trp) ? e_req && dmem_gnt : free;
      end
      e_load = s2_valid && e_ready && !flush;
      chk("dmem_req", dmem_req, e_req);
      if (e_req) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wen", dmem_wen, e_wen);
        chk("dmem_strb", dmem_strb, e_strb);
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (s2_valid) chk("s2_ready", s2_ready, e_ready);
      chk("s3_valid", s3_valid, m_s3v);
      if (m_s3v) begin
        chk("s3_pc", s3_pc, m_pc);
        chk("s3_wdata", s3_wdata, m_wdata);
        chk("s3_lsu_op", s3_lsu_op, m_op);
        chk("s3_trap", s3_trap, m_trap);
        if (m_trap) chk("s3_trap_cause", s3_trap_cause, m_cause);
      end
      if (m_pend) begin
        if (dmem_gnt) m_pend = 0;
        else if (flush) m_kill = 1;
      end else if (e_req && !dmem_gnt) begin
        m_pend = 1; m_kill = 0;
        p_addr = e_addr; p_wen = e_wen; p_strb = e_strb; p_wdata = e_wdata;
      end
      if (e_load) begin
        m_s3v = 1; m_pc = s2_pc; m_wdata = s2_addr; m_op = s2_lsu_op; m_trap = trp; m_cause = cause;
      end else if (flush || s3_ready) m_s3v = 0;
      acc = s2_valid && e_ready;
    end
  end

  initial begin
    @(negedge g_clk);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_s3_valid", s3_valid, 0);
    chk("rst_s3_lsu_op", s3_lsu_op, 0);
    #2 g_resetn = 1;
    drive(1, OP_ST | OP_W, 64'h1004, 64'hDEADBEEF, 0, 0, 1);
    chk("sw_req", dmem_req, 1);
    chk("sw_addr", dmem_addr, 64'h1000);
    chk("sw_strb", dmem_strb, 8'hF0);
    chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
    chk("sw_wen", dmem_wen, 1);
    chk("sw_ready", s2_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("sw_s3_valid", s3_valid, 1);
    chk("sw_s3_wdata", s3_wdata, 64'h1004);
    chk("sw_s3_trap", s3_trap, 0);
    drive(1, OP_LD | OP_H, 64'h2003, 0, 0, 0, 1);
    chk("lh_mis_req", dmem_req, 0);
    chk("lh_mis_ready", s2_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lh_mis_s3_valid", s3_valid, 1);
    chk("lh_mis_trap", s3_trap, 1);
    chk("lh_mis_cause", s3_trap_cause, 4);
    chk("lh_mis_wdata", s3_wdata, 64'h2003);
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_LD | OP_D, 64'h3000, 0, 0, 0, 0);
      chk("ld_wait_req", dmem_req, 1);
      chk("ld_wait_addr", dmem_addr, 64'h3000);
      chk("ld_wait_strb", dmem_strb, 8'hFF);
      chk("ld_wait_ready", s2_ready, 0);
    end
    drive(1, OP_LD | OP_D, 64'h3000, 0, 0, 0, 1);
    chk("ld_gnt_req", dmem_req, 1);
    chk("ld_gnt_ready", s2_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ld_gnt_s3_valid", s3_valid, 1);
    drive(1, OP_LD | OP_B, 64'h4000, 0, 0, 0, 0);
    drive(1, OP_LD | OP_B, 64'h4000, 0, 0, 0, 0);
    drive(1, OP_LD | OP_B, 64'h4000, 0, 0, 1, 0);
    chk("fl_ready", s2_ready, 0);
    drive(1, OP_LD | OP_B, 64'h4000, 0, 0, 0, 0);
    chk("drain_req", dmem_req, 1);
    chk("drain_ready", s2_ready, 0);
    chk("drain_s3_valid", s3_valid, 0);
    drive(1, OP_LD | OP_B, 64'h4000, 0, 0, 0, 1);
    chk("drain_gnt_req", dmem_req, 1);
    chk("drain_gnt_ready", s2_ready, 0);
    chk("drain_gnt_s3_valid", s3_valid, 0);
    drive(1, 0, 64'h5555, 0, 0, 0, 0);
    chk("post_drain_ready", s2_ready, 1);
    chk("post_drain_req", dmem_req, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_drain_s3_valid", s3_valid, 1);
    chk("post_drain_s3_wdata", s3_wdata, 64'h5555);
    drive(1, OP_LD | OP_W, 64'h6000, 0, 0, 0, 0);
    drive(1, OP_LD | OP_W, 64'h6000, 0, 0, 0, 0);
    chk("arst_pre_req", dmem_req, 1);
    #1 g_resetn = 0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_s3_valid", s3_valid, 0);
    s2_valid = 0;
    @(negedge g_clk);
    #2 g_resetn = 1;
    drive(1, OP_LD | OP_W, 64'h6000, 0, 0, 0, 1);
    chk("arst_idle_req", dmem_req, 1);
    chk("arst_idle_ready", s2_ready, 1);
    drive(1, OP_ST | OP_B, 64'h10, 64'hA5, 0, 0, 1);
    chk("b2b0_strb", dmem_strb, 8'h01);
    chk("b2b0_wdata", dmem_wdata, 64'hA5);
    chk("b2b0_ready", s2_ready, 1);
    drive(1, OP_ST | OP_B, 64'h17, 64'h5A, 0, 0, 1);
    chk("b2b1_req", dmem_req, 1);
    chk("b2b1_strb", dmem_strb, 8'h80);
    chk("b2b1_wdata", dmem_wdata, 64'h5A00_0000_0000_0000);
    chk("b2b1_ready", s2_ready, 1);
    chk("b2b1_s3_valid", s3_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_s3_wdata", s3_wdata, 64'h17);
    for (int n = 0; n < 4000; n++) begin
      @(posedge g_clk);
      #1;
      if (!s2_valid || acc) begin
        int k, sz_sel;
        logic [6:0] op;
        logic [63:0] a;
        k = $urandom_range(0, 7);
        sz_sel = $urandom_range(0, 3);
        op = 0;
        if (k >= 2) begin
          op = (($urandom % 2) != 0 ? OP_LD : OP_ST) | (OP_B << sz_sel);
          if (op[0] && ($urandom % 2) != 0) op = op | OP_SX;
        end
        a = {$urandom, $urandom};
        if (($urandom % 2) != 0) a = (a >> sz_sel) << sz_sel;
        s2_valid = ($urandom % 4) != 0;
        s2_lsu_op = op; s2_addr = a; s2_rs2 = {$urandom, $urandom}; s2_pc = {$urandom, $urandom};
        s2_trap = ($urandom % 16) == 0;
      end
      flush = ($urandom % 12) == 0;
      dmem_gnt = ($urandom % 3) != 0;
      s3_ready = ($urandom % 4) != 0;
    end
    @(negedge g_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
